// File: rtl/msrv32_rf_pkg.sv
// Shared register-file widths and the writeback entry type used by the
// B-result queue.
package msrv32_rf_pkg;

    localparam int                   RF_ADDR_W  = 5;
    localparam int                   RF_DATA_W  = 32;
    localparam logic [RF_ADDR_W-1:0] RF_X0_ADDR = 5'd0;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/msrv32_wb_fifo.sv
// Small synchronous FIFO of writeback entries with a two-port address lookup
// over the currently valid entries (used for stage-2 hazard detection).
module msrv32_wb_fifo
    import msrv32_rf_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                 clk_in,
    input  logic                 reset_in,
    input  logic                 i_push,
    input  logic [RF_ADDR_W-1:0] i_push_addr,
    input  logic [RF_DATA_W-1:0] i_push_data,
    input  logic                 i_pop,
    input  logic [RF_ADDR_W-1:0] i_lookup_1,
    input  logic [RF_ADDR_W-1:0] i_lookup_2,
    output logic [RF_ADDR_W-1:0] o_head_addr,
    output logic [RF_DATA_W-1:0] o_head_data,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [4:0]           o_count,
    output logic                 o_match_1,
    output logic                 o_match_2
);
    localparam int PTR_W = $clog2(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [4:0]       r_count;
    logic [DEPTH-1:0] w_valid;
    logic [DEPTH-1:0] w_hit_1;
    logic [DEPTH-1:0] w_hit_2;

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= '{addr: i_push_addr, data: i_push_data};
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (i_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (i_push && !i_pop) begin
                r_count <= r_count + 5'd1;
            end else if (!i_push && i_pop) begin
                r_count <= r_count - 5'd1;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [PTR_W-1:0] w_off;
        assign w_off      = PTR_W'(g) - r_rd_ptr;
        assign w_valid[g] = {{(5 - PTR_W){1'b0}}, w_off} < r_count;
        assign w_hit_1[g] = r_mem[g].addr == i_lookup_1;
        assign w_hit_2[g] = r_mem[g].addr == i_lookup_2;
    end

    assign o_match_1   = |(w_valid & w_hit_1);
    assign o_match_2   = |(w_valid & w_hit_2);
    assign o_head_addr = r_mem[r_rd_ptr].addr;
    assign o_head_data = r_mem[r_rd_ptr].data;
    assign o_full      = r_count == 5'(DEPTH);
    assign o_empty     = r_count == 5'd0;
    assign o_count     = r_count;

endmodule

// File: rtl/msrv32_rf_wb_arbiter.sv
// Register-file write-port arbiter: stage-3 writes have priority, queued
// long-latency results drain when stage 3 is idle or after MAX_WAIT losses.
module msrv32_rf_wb_arbiter
    import msrv32_rf_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8
) (
    input  logic        clk_in,
    input  logic        reset_in,
    input  logic        a_wr_en_in,
    input  logic [4:0]  a_rd_addr_in,
    input  logic [31:0] a_rd_in,
    output logic        a_ready_out,
    input  logic        b_valid_in,
    input  logic [4:0]  b_rd_addr_in,
    input  logic [31:0] b_rd_in,
    output logic        b_ready_out,
    output logic        wr_en_out,
    output logic [4:0]  rd_addr_out,
    output logic [31:0] rd_out,
    input  logic [4:0]  rs_1_addr_in,
    input  logic [4:0]  rs_2_addr_in,
    output logic        hazard_1_out,
    output logic        hazard_2_out,
    output logic [4:0]  pending_count_out
);
    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_a_req;
    logic                 w_a_grant;
    logic                 w_match_1;
    logic                 w_match_2;
    logic [RF_ADDR_W-1:0] w_head_addr;
    logic [RF_DATA_W-1:0] w_head_data;
    logic [4:0]           w_count;
    logic [7:0]           r_wait;

    assign w_a_req     = a_wr_en_in && (a_rd_addr_in != RF_X0_ADDR);
    assign b_ready_out = reset_in && !w_full;
    // x0 results are accepted but never occupy a queue slot.
    assign w_push      = b_ready_out && b_valid_in && (b_rd_addr_in != RF_X0_ADDR);

    always_comb begin
        w_pop     = 1'b0;
        w_a_grant = 1'b1;
        if (!w_empty) begin
            if (!w_a_req) begin
                w_pop = 1'b1;
            end else if (r_wait >= 8'(MAX_WAIT)) begin
                w_pop     = 1'b1;
                w_a_grant = 1'b0;
            end
        end
        if (!reset_in) begin
            w_pop     = 1'b0;
            w_a_grant = 1'b0;
        end
    end

    assign a_ready_out = w_a_grant;

    always_comb begin
        wr_en_out   = 1'b0;
        rd_addr_out = '0;
        rd_out      = '0;
        if (w_pop) begin
            wr_en_out   = 1'b1;
            rd_addr_out = w_head_addr;
            rd_out      = w_head_data;
        end else if (w_a_grant && w_a_req) begin
            wr_en_out   = 1'b1;
            rd_addr_out = a_rd_addr_in;
            rd_out      = a_rd_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_in) begin
            r_wait <= '0;
        end else if (w_empty || w_pop) begin
            r_wait <= '0;
        end else if (w_a_req && (r_wait < 8'(MAX_WAIT))) begin
            r_wait <= r_wait + 8'd1;
        end
    end

    assign hazard_1_out = reset_in && (rs_1_addr_in != RF_X0_ADDR) &&
                          (w_match_1 || (w_push && (b_rd_addr_in == rs_1_addr_in)));
    assign hazard_2_out = reset_in && (rs_2_addr_in != RF_X0_ADDR) &&
                          (w_match_2 || (w_push && (b_rd_addr_in == rs_2_addr_in)));
    assign pending_count_out = w_count;

    msrv32_wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in      (clk_in),
        .reset_in    (reset_in),
        .i_push      (w_push),
        .i_push_addr (b_rd_addr_in),
        .i_push_data (b_rd_in),
        .i_pop       (w_pop),
        .i_lookup_1  (rs_1_addr_in),
        .i_lookup_2  (rs_2_addr_in),
        .o_head_addr (w_head_addr),
        .o_head_data (w_head_data),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_count     (w_count),
        .o_match_1   (w_match_1),
        .o_match_2   (w_match_2)
    );

endmodule

// File: tb/tb_msrv32_rf_wb_arbiter.sv
// Scoreboard bench: a queue-based reference model predicts each cycle's
// outputs and the register-file write stream; a monitor compares them.
module tb_msrv32_rf_wb_arbiter;
    localparam int DEPTH = 4;
    localparam int MAXW  = 8;

    logic        clk_in = 1'b0;
    logic        reset_in;
    logic        a_wr_en_in;
    logic [4:0]  a_rd_addr_in;
    logic [31:0] a_rd_in;
    logic        a_ready_out;
    logic        b_valid_in;
    logic [4:0]  b_rd_addr_in;
    logic [31:0] b_rd_in;
    logic        b_ready_out;
    logic        wr_en_out;
    logic [4:0]  rd_addr_out;
    logic [31:0] rd_out;
    logic [4:0]  rs_1_addr_in;
    logic [4:0]  rs_2_addr_in;
    logic        hazard_1_out;
    logic        hazard_2_out;
    logic [4:0]  pending_count_out;

    always #5 clk_in = ~clk_in;

    msrv32_rf_wb_arbiter #(
        .FIFO_DEPTH (DEPTH),
        .MAX_WAIT   (MAXW)
    ) dut (
        .clk_in            (clk_in),
        .reset_in          (reset_in),
        .a_wr_en_in        (a_wr_en_in),
        .a_rd_addr_in      (a_rd_addr_in),
        .a_rd_in           (a_rd_in),
        .a_ready_out       (a_ready_out),
        .b_valid_in        (b_valid_in),
        .b_rd_addr_in      (b_rd_addr_in),
        .b_rd_in           (b_rd_in),
        .b_ready_out       (b_ready_out),
        .wr_en_out         (wr_en_out),
        .rd_addr_out       (rd_addr_out),
        .rd_out            (rd_out),
        .rs_1_addr_in      (rs_1_addr_in),
        .rs_2_addr_in      (rs_2_addr_in),
        .hazard_1_out      (hazard_1_out),
        .hazard_2_out      (hazard_2_out),
        .pending_count_out (pending_count_out)
    );

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic        ardy;
        logic        brdy;
        logic        wr;
        logic        h1;
        logic        h2;
        logic [4:0]  pc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    ent_t mq[$];
    ent_t wq[$];
    exp_t sq[$];
    int   mwait  = 0;
    int   checks = 0;
    int   errors = 0;
    logic last_ardy = 1'b1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    function automatic bit in_queue(input logic [4:0] a);
        foreach (mq[i]) if (mq[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic cycle(input logic rst_n, input logic a_en, input logic [4:0] a_addr,
                         input logic [31:0] a_data, input logic b_v, input logic [4:0] b_addr,
                         input logic [31:0] b_data, input logic [4:0] rs1, input logic [4:0] rs2);
        exp_t e;
        ent_t h;
        bit   push, pop, areq, was_empty;
        @(negedge clk_in);
        reset_in     = rst_n;
        a_wr_en_in   = a_en;
        a_rd_addr_in = a_addr;
        a_rd_in      = a_data;
        b_valid_in   = b_v;
        b_rd_addr_in = b_addr;
        b_rd_in      = b_data;
        rs_1_addr_in = rs1;
        rs_2_addr_in = rs2;
        e = '{default: '0};
        e.pc = 5'(mq.size());
        if (!rst_n) begin
            mq.delete();
            mwait = 0;
        end else begin
            areq      = a_en && (a_addr != 5'd0);
            was_empty = (mq.size() == 0);
            e.brdy    = (mq.size() < DEPTH);
            push      = b_v && e.brdy && (b_addr != 5'd0);
            e.h1      = (rs1 != 5'd0) && (in_queue(rs1) || (push && b_addr == rs1));
            e.h2      = (rs2 != 5'd0) && (in_queue(rs2) || (push && b_addr == rs2));
            pop       = 1'b0;
            e.ardy    = 1'b1;
            if (!was_empty) begin
                if (!areq) pop = 1'b1;
                else if (mwait >= MAXW) begin
                    pop    = 1'b1;
                    e.ardy = 1'b0;
                end
            end
            if (pop) begin
                h      = mq.pop_front();
                e.wr   = 1'b1;
                e.addr = h.addr;
                e.data = h.data;
            end else if (areq) begin
                e.wr   = 1'b1;
                e.addr = a_addr;
                e.data = a_data;
            end
            if (was_empty || pop) mwait = 0;
            else if (areq && mwait < MAXW) mwait++;
            if (push) mq.push_back('{addr: b_addr, data: b_data});
            if (e.wr) wq.push_back('{addr: e.addr, data: e.data});
        end
        last_ardy = e.ardy;
        sq.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        ent_t w;
        forever begin
            @(negedge clk_in);
            #2;
            if (sq.size() > 0) begin
                e = sq.pop_front();
                chk("a_ready", 32'(a_ready_out), 32'(e.ardy));
                chk("b_ready", 32'(b_ready_out), 32'(e.brdy));
                chk("wr_en", 32'(wr_en_out), 32'(e.wr));
                chk("hazard_1", 32'(hazard_1_out), 32'(e.h1));
                chk("hazard_2", 32'(hazard_2_out), 32'(e.h2));
                chk("pending_count", 32'(pending_count_out), 32'(e.pc));
                if (wr_en_out === 1'b1) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_write at %0t: got addr %h expected no write",
                                 $time, rd_addr_out);
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(rd_addr_out), 32'(w.addr));
                        chk("wr_data", rd_out, w.data);
                    end
                end else begin
                    chk("idle_addr", 32'(rd_addr_out), 32'(e.addr));
                    chk("idle_data", rd_out, e.data);
                end
            end
        end
    end

    initial begin : stimulus
        logic        ra_en;
        logic [4:0]  ra_addr;
        logic [31:0] ra_data;
        reset_in     = 1'b0;
        a_wr_en_in   = 1'b0;
        a_rd_addr_in = '0;
        a_rd_in      = '0;
        b_valid_in   = 1'b0;
        b_rd_addr_in = '0;
        b_rd_in      = '0;
        rs_1_addr_in = '0;
        rs_2_addr_in = '0;
        repeat (2) @(negedge clk_in);

        // idle drain with hazard lookup
        cycle(1, 0, 0, 0, 1, 7, 32'hDEAD, 7, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 7, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 7, 0);

        // starvation: one queued entry, A writing continuously
        cycle(1, 1, 3, 32'h300, 1, 9, 32'h900, 9, 3);
        for (int i = 0; i < 11; i++) cycle(1, 1, 3, 32'h301 + i, 0, 0, 0, 9, 3);

        // full queue, rejected offer while popping, accepted next cycle
        for (int i = 0; i < 4; i++) cycle(1, 1, 1, 32'h100 + i, 1, 5'(10 + i), 32'hB0 + i, 12, 0);
        cycle(1, 0, 0, 0, 1, 20, 32'hB5, 20, 10);
        cycle(1, 0, 0, 0, 1, 20, 32'hB5, 20, 10);
        repeat (6) cycle(1, 0, 0, 0, 0, 0, 0, 20, 11);

        // x0 on both sources
        cycle(1, 0, 0, 0, 1, 0, 32'hBAD0, 0, 0);
        cycle(1, 1, 2, 32'h22, 1, 4, 32'h44, 4, 0);
        cycle(1, 1, 0, 32'h55, 0, 0, 0, 4, 0);
        cycle(1, 0, 0, 0, 0, 0, 0, 4, 0);

        // duplicate addresses drain in order
        cycle(1, 0, 0, 0, 1, 5, 32'h1, 0, 5);
        cycle(1, 0, 0, 0, 1, 5, 32'h2, 0, 5);
        repeat (3) cycle(1, 0, 0, 0, 0, 0, 0, 0, 5);

        // reset mid-drain, then a fresh entry
        for (int i = 0; i < 3; i++) cycle(1, 1, 6, 32'h60 + i, 1, 5'(24 + i), 32'hC0 + i, 25, 26);
        cycle(1, 0, 0, 0, 0, 0, 0, 25, 26);
        cycle(0, 0, 0, 0, 1, 27, 32'hEE, 25, 26);
        cycle(1, 0, 0, 0, 0, 0, 0, 25, 26);
        cycle(1, 0, 0, 0, 1, 8, 32'h88, 8, 25);
        repeat (2) cycle(1, 0, 0, 0, 0, 0, 0, 8, 25);

        // randomized traffic; stage 3 holds its request while not accepted
        ra_en = 1'b0; ra_addr = '0; ra_data = '0;
        for (int n = 0; n < 3000; n++) begin
            if (last_ardy || !ra_en) begin
                ra_en   = ($urandom_range(0, 99) < 60);
                ra_addr = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
                ra_data = $urandom;
            end
            cycle(($urandom_range(0, 199) != 0), ra_en, ra_addr, ra_data,
                  ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 7)), $urandom,
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
        end
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (DEPTH + 2) cycle(1, 0, 0, 0, 0, 0, 0, 0, 0);

        @(negedge clk_in);
        #3;
        chk("leftover_writes", 32'(wq.size()), 32'd0);
        chk("leftover_cycles", 32'(sq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/msrv32_rf_wb_arbiter.md
Name: msrv32_rf_wb_arbiter

Overview:
- Shares the single register-file write port (rd_addr/wr_en/rd data) between two writeback sources.
- Source A is the in-order pipeline stage 3 and has priority.
- Source B is a long-latency unit (load/divide); its results are buffered in a small FIFO and drained when A is idle, or forcibly after a starvation limit.
- Also gives stage 2 a pending-write hazard lookup, so it stalls on registers whose B result is still queued.

Parameters:
- FIFO_DEPTH, 4: B result queue entries; power of two, 2..16.
- MAX_WAIT, 8: cycles a non-empty queue head may lose to A before it is forced through; 1..255.

Ports:
- clk_in  input  1  clock, rising edge.
- reset_in  input  1  reset, synchronous, active-low.
- a_wr_en_in  input  1  stage-3 writeback request.
- a_rd_addr_in  input  5  stage-3 destination register.
- a_rd_in  input  32  stage-3 write data.
- a_ready_out  output  1  A write accepted this cycle; when low, stage 3 must hold.
- b_valid_in  input  1  B result valid.
- b_rd_addr_in  input  5  B destination register.
- b_rd_in  input  32  B write data.
- b_ready_out  output  1  B result accepted on this edge.
- wr_en_out  output  1  register-file write enable.
- rd_addr_out  output  5  register-file write address.
- rd_out  output  32  register-file write data.
- rs_1_addr_in  input  5  stage-2 source 1 address.
- rs_2_addr_in  input  5  stage-2 source 2 address.
- hazard_1_out  output  1  rs_1 has a queued or incoming B write.
- hazard_2_out  output  1  rs_2 has a queued or incoming B write.
- pending_count_out  output  5  queued B entries (registered).

Behaviour:
- Reset (reset_in low at posedge): pointers, count, wait_cnt and pending_count_out go to 0, and queue contents are discarded, including mid-drain.
  - While reset_in is low, all outputs are forced to 0: wr_en_out, a_ready_out, b_ready_out and both hazards.
- B enqueue:
  - b_ready_out = not full; no pass-through when full, even if a pop occurs in the same cycle.
  - On b_valid_in and b_ready_out with b_rd_addr_in != 0, the entry is pushed at the edge.
  - With b_rd_addr_in == 0, the result is accepted and dropped; no entry is created.
- B latency: B never writes directly. Minimum latency is 1 cycle: pushed at edge t, head is visible in cycle t+1 and written at edge t+2 if granted.
- Grant (combinational, each cycle):
  - Queue empty: A granted, a_ready_out=1.
  - Queue non-empty, a_wr_en_in=0: head granted and popped, a_ready_out=1.
  - Queue non-empty, a_wr_en_in=1 and wait_cnt < MAX_WAIT: A granted, head not popped.
  - Queue non-empty, a_wr_en_in=1 and wait_cnt == MAX_WAIT: head granted and popped, a_ready_out=0.
- A write to x0: treated as no request. a_ready_out=1, A produces no write, and the head may drain in the same cycle.
- Write outputs:
  - wr_en_out=1 only for a granted, non-x0 write.
  - rd_addr_out/rd_out come from the granted source. When wr_en_out=0 their values are don't-care; drive 0.
- wait_cnt (saturating at MAX_WAIT):
  - Cleared when the queue is empty or on a pop.
  - Otherwise increments each cycle the head loses to A.
- Simultaneous push and pop: both happen and the count is unchanged. Push into the empty queue while A is idle: no write that cycle.
- Ordering: queue entries drain FIFO-order, so duplicate addresses resolve last-wins.
- Hazards:
  - hazard_k_out=1 when rs_k_addr_in != 0 and it matches any valid queue entry address, or an accepted push this cycle.
  - x0 never hazards.
  - Integration rule: stage 2 stalls issue on a hazard. This guarantees no A write to an address still queued from B (no WAW inversion).
- pending_count_out updates at each edge; range 0..FIFO_DEPTH.

Decomposition:
- Package msrv32_rf_pkg holds:
  - RF_ADDR_W=5, RF_DATA_W=32, RF_X0_ADDR=5'd0.
  - A writeback-entry struct {addr, data}.
- One sub-module, msrv32_wb_fifo:
  - Synchronous FIFO with push, pop, full, empty and count.
  - Per-entry valid/address compare against two lookup addresses, giving two match outputs.
- Arbitration, wait_cnt and output muxing stay in msrv32_rf_wb_arbiter.

Test Plan:
- Reset dominance: fill 3 entries, then pull reset_in low mid-drain for 1 cycle → pending_count_out=0, wr_en_out=0, all hazards 0; a later head shows no stale data.
- Idle drain: push B (addr 7, 0xDEAD) at edge t with A idle → hazard_1_out=1 for rs_1=7 in cycle t; wr_en_out=1, rd_addr_out=7, rd_out=0xDEAD in cycle t+1; hazard clears after edge t+2.
- Starvation with MAX_WAIT=8: one B entry queued, A writes continuously → A wins 8 cycles; in the 9th, a_ready_out=0 and the head is written; a_ready_out=1 the next cycle.
- Full queue at FIFO_DEPTH=4: push 4 entries with A busy → b_ready_out=0; a simultaneous pop does not accept a 5th entry that cycle; a 5th offer is accepted the next cycle.
- x0 handling: B push with addr 0 → accepted, pending_count_out unchanged. A write with addr 0 while the queue is non-empty → head drains that cycle, a_ready_out=1.
- Duplicate addresses: queue addr 5 twice (0x1 then 0x2), A idle → writes occur in order 0x1 then 0x2; hazard_2_out for rs_2=5 stays 1 until the second write's edge.
